// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: forwarding-select and load-use interlock unit for the pipelined MIPS core.
// Tracks in-flight destination registers from EX through the last forwarding stage,
// produces registered operand-forward selects for EX and a combinational load-use stall.
// Optional feature: define FWD_HAZARD_PERF_CNT_EN to build the saturating stall-cycle counter;
// without it stall_cycles is tied to zero.
module fwd_hazard_unit #(
   parameter int REG_ADDR_W       = 5,
   parameter int NUM_FWD_STAGES   = 2,
   parameter int LOAD_READY_STAGE = 2,
   localparam int FWD_W           = $clog2(NUM_FWD_STAGES + 1)
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  hold,
   input  logic                  flush,
   input  logic                  id_valid,
   input  logic [REG_ADDR_W-1:0] id_rs,
   input  logic [REG_ADDR_W-1:0] id_rt,
   input  logic                  id_use_rs,
   input  logic                  id_use_rt,
   input  logic                  id_reg_write,
   input  logic                  id_mem_read,
   input  logic [REG_ADDR_W-1:0] id_write_reg,
   output logic                  stall,
   output logic [FWD_W-1:0]      fwd_a,
   output logic [FWD_W-1:0]      fwd_b,
   output logic [31:0]           stall_cycles
);

   typedef struct packed {
      logic                  valid;
      logic                  regWrite;
      logic                  memRead;
      logic [REG_ADDR_W-1:0] dest;
   } tagT;

   // Slot 0 is the instruction in EX, slot j the one in post-EX stage j.
   tagT slots [NUM_FWD_STAGES];

   logic [REG_ADDR_W-1:0] srcAddr [2];
   logic                  srcUse  [2];
   logic [FWD_W-1:0]      srcSel  [2];
   logic [1:0]            srcHaz;
   logic                  enterEx;
   tagT                   idTag;

   assign srcAddr[0] = id_rs;
   assign srcAddr[1] = id_rt;
   assign srcUse[0]  = id_use_rs;
   assign srcUse[1]  = id_use_rt;

   assign idTag = '{valid: 1'b1, regWrite: id_reg_write, memRead: id_mem_read, dest: id_write_reg};

   // For each used source, find the youngest producer of that register and decide between
   // forwarding from its stage or interlocking until its result is ready. The scan runs from the
   // oldest slot to the youngest so the youngest match is the one that sticks.
   always_comb begin
      for (int s = 0; s < 2; s++) begin
         srcSel[s] = '0;
         srcHaz[s] = 1'b0;
         if (id_valid && srcUse[s] && (srcAddr[s] != '0)) begin
            for (int j = NUM_FWD_STAGES - 1; j >= 0; j--) begin
               if (slots[j].valid && slots[j].regWrite && (slots[j].dest != '0) &&
                   (slots[j].dest == srcAddr[s])) begin
                  if ((j + 1) < (slots[j].memRead ? LOAD_READY_STAGE : 1)) begin
                     srcHaz[s] = 1'b1;
                     srcSel[s] = '0;
                  end else begin
                     srcHaz[s] = 1'b0;
                     srcSel[s] = FWD_W'(j + 1);
                  end
               end
            end
         end
      end
   end

   // A squashed instruction never stalls; otherwise either source hazard holds IF/ID.
   assign stall   = id_valid & ~flush & (|srcHaz);
   assign enterEx = id_valid & ~flush & ~stall;

   // Advance the tag pipeline and register the EX forward selects unless the pipeline is frozen.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int j = 0; j < NUM_FWD_STAGES; j++) begin
            slots[j] <= '0;
         end
         fwd_a <= '0;
         fwd_b <= '0;
      end else if (!hold) begin
         for (int j = NUM_FWD_STAGES - 1; j > 0; j--) begin
            slots[j] <= slots[j-1];
         end
         slots[0] <= enterEx ? idTag : '0;
         fwd_a    <= enterEx ? srcSel[0] : '0;
         fwd_b    <= enterEx ? srcSel[1] : '0;
      end
   end

`ifdef FWD_HAZARD_PERF_CNT_EN
   logic [31:0] stallCount;

   // Count live (non-frozen) stall cycles, sticking at the all-ones value instead of wrapping.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stallCount <= '0;
      end else if (!hold && stall && (stallCount != 32'hFFFF_FFFF)) begin
         stallCount <= stallCount + 32'd1;
      end
   end

   assign stall_cycles = stallCount;
`else
   assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb_fwd_hazard_unit: directed-vector scoreboard bench for fwd_hazard_unit (default parameters).
// The driver applies one vector per cycle and queues the outputs expected during that cycle;
// a monitor on the falling edge pops each entry and compares it with the DUT.
module tb_fwd_hazard_unit;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       hold = 1'b0;
   logic       flush = 1'b0;
   logic       id_valid = 1'b0;
   logic [4:0] id_rs = '0;
   logic [4:0] id_rt = '0;
   logic       id_use_rs = 1'b0;
   logic       id_use_rt = 1'b0;
   logic       id_reg_write = 1'b0;
   logic       id_mem_read = 1'b0;
   logic [4:0] id_write_reg = '0;
   logic       stall;
   logic [1:0] fwd_a;
   logic [1:0] fwd_b;
   logic [31:0] stall_cycles;

   typedef struct {
      string       name;
      logic        expStall;
      logic [1:0]  expFwdA;
      logic [1:0]  expFwdB;
      logic [31:0] expCnt;
   } expT;

   expT expQ [$];
   int  total = 0;
   int  bad = 0;

   fwd_hazard_unit dut (
      .clk(clk), .reset_n(reset_n), .hold(hold), .flush(flush), .id_valid(id_valid),
      .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
      .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_write_reg(id_write_reg),
      .stall(stall), .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_cycles(stall_cycles)
   );

   // Free-running 10-unit clock.
   always #5 clk = ~clk;

   // Compare one queued expectation against the current DUT outputs.
   task automatic checkOutput(input expT e);
      logic [31:0] wantCnt;
`ifdef FWD_HAZARD_PERF_CNT_EN
      wantCnt = e.expCnt;
`else
      wantCnt = 32'd0;
`endif
      total++;
      if (stall !== e.expStall) begin
         bad++;
         $display("[TB] FAIL %s stall: got %0b want %0b", e.name, stall, e.expStall);
      end
      total++;
      if (fwd_a !== e.expFwdA) begin
         bad++;
         $display("[TB] FAIL %s fwd_a: got %0d want %0d", e.name, fwd_a, e.expFwdA);
      end
      total++;
      if (fwd_b !== e.expFwdB) begin
         bad++;
         $display("[TB] FAIL %s fwd_b: got %0d want %0d", e.name, fwd_b, e.expFwdB);
      end
      total++;
      if (stall_cycles !== wantCnt) begin
         bad++;
         $display("[TB] FAIL %s stall_cycles: got %0d want %0d", e.name, stall_cycles, wantCnt);
      end
   endtask

   // Monitor: mid-cycle, pop and check whatever the driver queued for this cycle.
   always @(negedge clk) begin
      if (expQ.size() > 0) begin
         checkOutput(expQ.pop_front());
      end
   end

   // Drive one cycle's inputs just after the rising edge and queue the hand-computed outputs.
   task automatic applyStimulus(
      input string name, input logic rst, input logic hld, input logic fl, input logic vld,
      input int rs, input int rt, input logic useRs, input logic useRt,
      input logic rw, input logic mr, input int wd,
      input logic eStall, input int eA, input int eB, input int eCnt);
      expT e;
      @(posedge clk);
      #1;
      reset_n      = rst;
      hold         = hld;
      flush        = fl;
      id_valid     = vld;
      id_rs        = 5'(rs);
      id_rt        = 5'(rt);
      id_use_rs    = useRs;
      id_use_rt    = useRt;
      id_reg_write = rw;
      id_mem_read  = mr;
      id_write_reg = 5'(wd);
      e.name     = name;
      e.expStall = eStall;
      e.expFwdA  = 2'(eA);
      e.expFwdB  = 2'(eB);
      e.expCnt   = 32'(eCnt);
      expQ.push_back(e);
   endtask

   // Directed sequence; fields: name rst hold flush valid rs rt useRs useRt rw mr wd | stall fwdA fwdB cnt
   initial begin
      applyStimulus("reset",        0,0,0,0,  0, 0, 0,0, 0,0, 0,  0,0,0,0);
      applyStimulus("idle",         1,0,0,0,  0, 0, 0,0, 0,0, 0,  0,0,0,0);
      applyStimulus("alu_add3",     1,0,0,1,  1, 2, 1,1, 1,0, 3,  0,0,0,0);
      applyStimulus("alu_sub_rs3",  1,0,0,1,  3, 4, 1,1, 1,0, 8,  0,0,0,0);
      applyStimulus("alu_fwd_a1",   1,0,0,0,  0, 0, 0,0, 0,0, 0,  0,1,0,0);
      applyStimulus("d2_add3",      1,0,0,1,  1, 2, 1,1, 1,0, 3,  0,0,0,0);
      applyStimulus("d2_nop",       1,0,0,0,  0, 0, 0,0, 0,0, 0,  0,0,0,0);
      applyStimulus("d2_or_rt3",    1,0,0,1,  1, 3, 1,1, 1,0, 9,  0,0,0,0);
      applyStimulus("d3_rt3",       1,0,0,1,  1, 3, 1,1, 0,0,10,  0,0,2,0);
      applyStimulus("d3_fwd0",      1,0,0,0,  0, 0, 0,0, 0,0, 0,  0,0,0,0);
      applyStimulus("lu_lw5",       1,0,0,1,  1, 0, 1,0, 1,1, 5,  0,0,0,0);
      applyStimulus("lu_stall",     1,0,0,1,  6, 5, 1,1, 1,0,11,  1,0,0,0);
      applyStimulus("lu_bubble",    1,0,0,1,  6, 5, 1,1, 1,0,11,  0,0,0,1);
      applyStimulus("lu_fwd_b2",    1,0,0,0,  0, 0, 0,0, 0,0, 0,  0,0,2,1);
      applyStimulus("yg_add7",      1,0,0,1,  1, 2, 1,1, 1,0, 7,  0,0,0,1);
      applyStimulus("yg_sub7",      1,0,0,1,  1, 2, 1,1, 1,0, 7,  0,0,0,1);
      applyStimulus("yg_use7",      1,0,0,1,  7, 7, 1,1, 1,0,12,  0,0,0,1);
      applyStimulus("z_lw0",        1,0,0,1,  1, 2, 1,1, 1,1, 0,  0,1,1,1);
      applyStimulus("z_use0",       1,0,0,1,  0, 0, 1,1, 1,0,13,  0,0,0,1);
      applyStimulus("nouse_rs13",   1,0,0,1, 13, 2, 0,1, 1,0,14,  0,0,0,1);
      applyStimulus("nouse_chk",    1,0,0,0,  0, 0, 0,0, 0,0, 0,  0,0,0,1);
      applyStimulus("h_add1",       1,0,0,1,  2, 2, 1,1, 1,0, 1,  0,0,0,1);
      applyStimulus("h_lw5",        1,0,0,1,  1, 0, 1,0, 1,1, 5,  0,0,0,1);
      applyStimulus("h_hold1",      1,1,0,1,  2, 5, 1,1, 1,0,16,  1,1,0,1);
      applyStimulus("h_hold2",      1,1,0,1,  2, 5, 1,1, 1,0,16,  1,1,0,1);
      applyStimulus("h_hold3",      1,1,0,1,  2, 5, 1,1, 1,0,16,  1,1,0,1);
      applyStimulus("h_release",    1,0,0,1,  2, 5, 1,1, 1,0,16,  1,1,0,1);
      applyStimulus("h_enter",      1,0,0,1,  2, 5, 1,1, 1,0,16,  0,0,0,2);
      applyStimulus("h_fwd_b2",     1,0,0,0,  0, 0, 0,0, 0,0, 0,  0,0,2,2);
      applyStimulus("f_lw6",        1,0,0,1,  0, 0, 0,0, 1,1, 6,  0,0,0,2);
      applyStimulus("f_flush",      1,0,1,1,  2, 6, 1,1, 1,0,17,  0,0,0,2);
      applyStimulus("f_use17",      1,0,0,1, 17, 6, 1,1, 1,0,18,  0,0,0,2);
      applyStimulus("r_lw5",        1,0,0,1, 18, 0, 1,0, 1,1, 5,  0,0,2,2);
      applyStimulus("r_stall_h1",   1,1,0,1, 18, 5, 1,1, 1,0,19,  1,1,0,2);
      applyStimulus("r_stall_h2",   1,1,0,1, 18, 5, 1,1, 1,0,19,  1,1,0,2);
      applyStimulus("r_reset",      0,0,0,1, 18, 5, 1,1, 1,0,19,  0,0,0,0);
      applyStimulus("r_release",    1,0,0,0,  0, 0, 0,0, 0,0, 0,  0,0,0,0);
      applyStimulus("r_after",      1,0,0,1, 18, 5, 1,1, 1,0,19,  0,0,0,0);
      for (int i = 0; i < 10 && expQ.size() != 0; i++) begin
         @(negedge clk);
      end
      #1;
      if (expQ.size() != 0) begin
         total++;
         bad++;
         $display("[TB] FAIL drain: got %0d pending want 0", expQ.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
